dht11_poll_ctrl: RTL and testbench
==================================

Name: dht11_poll_ctrl

Overview:
- Sequencer that sits directly downstream of the DHT11 single-wire reader and drives it.
- Issues a properly stretched start request to the reader, then waits for its done edge with a timeout.
- Re-verifies the 40-bit frame checksum itself, then latches humidity and temperature bytes for the host/display logic.
- Enforces the sensor's minimum re-read interval; supports single-shot requests and free-running auto polling.

Parameters:
- START_HOLD_CYC, 128, clk cycles `sens_start` is held high; must be at least 2 periods of the reader's ~1 MHz sampling tick.
- TIMEOUT_CYC, 2_500_000, clk cycles allowed from start release to a `sens_done` rising edge (50 ms at 50 MHz).
- GAP_CYC, 50_000_000, minimum clk cycles between the end of one transaction and the next start (1 s).
- CNT_W, 26, width of the shared cycle counter; must hold max(START_HOLD_CYC, TIMEOUT_CYC, GAP_CYC).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  1  single-shot measurement request; level-sampled, latched as pending
- auto_en  in  1  when 1, a new transaction starts automatically after every gap
- sens_start  out  1  start request to the reader
- sens_data  in  40  frame from the reader: {hum_int, hum_dec, temp_int, temp_dec, checksum}
- sens_done  in  1  reader done level; high for ~51 clk cycles
- sens_error  in  1  reader's combinational checksum flag; used only for the mismatch counter
- hum_int, hum_dec, temp_int, temp_dec  out  8 each  last good reading
- valid  out  1  one-cycle pulse when a good reading is latched
- status  out  2  result of the last transaction: 00 ok, 01 checksum, 10 timeout, 11 never run
- busy  out  1  high in every state except IDLE
- err_cnt  out  8  saturating count of failed transactions

Behaviour:
- Reset (async, rst=1):
  - State IDLE, pending=0.
  - sens_start=0, valid=0, busy=0.
  - All data outputs 0, status=11, err_cnt=0.
  - Counter 0; done edge register 0.
- `sens_done` is registered once. `done_rise` = current & ~previous.
- Pending latch: set by req=1 in any state; cleared on entry to START. A req during GAP or a transaction is therefore served after the gap, never dropped.
- IDLE:
  - If pending or auto_en: go to START, counter=0.
- START:
  - sens_start=1.
  - When counter == START_HOLD_CYC-1: sens_start=0, counter=0, go to WAIT.
- WAIT:
  - If done_rise: capture sens_data into an internal frame register, go to CHECK.
  - Else if counter == TIMEOUT_CYC-1: status=10, increment err_cnt, counter=0, go to GAP.
- CHECK (1 cycle):
  - sum = (b39..32 + b31..24 + b23..16 + b15..8) mod 256, computed 8-bit wrapping.
  - If sum == b7..0: latch the four data outputs, status=00, valid=1 for exactly this cycle.
  - Else: data outputs keep their old values, status=01, increment err_cnt.
  - Go to GAP, counter=0.
- GAP:
  - When counter == GAP_CYC-1: go to IDLE.
  - A pending req is served from IDLE on the next cycle, so latency from gap end to sens_start is 2 cycles.
- err_cnt saturates at 255.
- busy = (state != IDLE).
- A done_rise seen outside WAIT is ignored.
- sens_error disagreeing with the local check has no effect on control; the local check is authoritative.
- Reset mid-transaction returns to IDLE with sens_start low within the same cycle (async).

Optional Feature:
- DHT11_RETRY_EN: adds parameter MAX_RETRY (default 2) and a retry counter.
- With the macro: a timeout or checksum failure with retries < MAX_RETRY skips status/err_cnt update and goes to GAP. At gap end it re-enters START regardless of pending/auto_en, retries+1. Only the final failure updates status and err_cnt. Retries clear on success or on final failure.
- Without the macro: every failure is reported immediately, as above.

Decomposition:
- Package dht11_pkg holds:
  - the state enum: IDLE, START, WAIT, CHECK, GAP;
  - status codes ST_OK, ST_CSUM, ST_TIMEOUT, ST_NONE;
  - byte-field offset constants for the 40-bit frame.
- One natural sub-module, dht11_csum: combinational 4-byte mod-256 sum compare. It is reused by the display-side formatter.
- Everything else stays in one module.

Test Plan (small params: START_HOLD_CYC=4, TIMEOUT_CYC=50, GAP_CYC=20):
- Good frame: req pulse; model raises sens_done 10 cycles after sens_start falls, with sens_data=40'h35_00_18_00_4D. Expect sens_start high exactly 4 cycles, valid single pulse, hum_int=0x35, temp_int=0x18, status=00, err_cnt=0.
- Bad checksum: sens_data=40'h35_00_18_00_4E. Expect no valid, outputs keep 0x35/0x18, status=01, err_cnt=1.
- Timeout: no sens_done. Expect status=10 exactly 50 cycles after sens_start falls, busy until 20 gap cycles elapse.
- Req during GAP: second req arrives 5 cycles into GAP. Expect the next sens_start rise exactly 2 cycles after the gap ends, with no second req needed.
- Wrap/auto: auto_en=1, frame 40'hFF_FF_FF_FF_FC (sum wraps to 0xFC). Expect valid, status=00, and back-to-back transactions separated by 20-cycle gaps.
- Reset mid-WAIT: assert rst asynchronously. Expect sens_start=0, busy=0, status=11 immediately. A following done_rise is ignored.

Source files
------------

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared constants and frame layout for the DHT11 polling controller.
//   - FSM state codes (S_IDLE .. S_GAP)
//   - transaction status codes (ST_OK, ST_CSUM, ST_TIMEOUT, ST_NONE)
//   - byte offsets inside the 40-bit sensor frame and a packed frame view
package dht11_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned FRAME_W = 40;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_START = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] S_CHECK = 3'd3;
    localparam logic [STATE_W-1:0] S_GAP   = 3'd4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CSUM    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_NONE    = 2'b11;

    // Byte lane offsets: {hum_int, hum_dec, temp_int, temp_dec, checksum}
    localparam int unsigned HUM_INT_LSB  = 32;
    localparam int unsigned HUM_DEC_LSB  = 24;
    localparam int unsigned TEMP_INT_LSB = 16;
    localparam int unsigned TEMP_DEC_LSB = 8;
    localparam int unsigned CSUM_LSB     = 0;

    typedef struct packed {
        logic [BYTE_W-1:0] hum_int;
        logic [BYTE_W-1:0] hum_dec;
        logic [BYTE_W-1:0] temp_int;
        logic [BYTE_W-1:0] temp_dec;
        logic [BYTE_W-1:0] csum;
    } dht11_frame_t;

    // Extract one byte lane from a raw frame
    function automatic logic [BYTE_W-1:0] frame_byte(input logic [FRAME_W-1:0] f,
                                                     input int unsigned lsb);
        return f[lsb +: BYTE_W];
    endfunction

endpackage

// File: rtl/dht11_csum.sv
// dht11_csum: combinational DHT11 checksum compare.
//   frame   in  40  raw frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   match_c out 1   1 when the 8-bit wrapping sum of the four data bytes equals the checksum byte
module dht11_csum
    import dht11_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               match_c
);

    logic [BYTE_W-1:0] sum;

    // Sum is truncated to 8 bits so it wraps mod 256
    always_comb begin
        sum     = frame_byte(frame, HUM_INT_LSB)  + frame_byte(frame, HUM_DEC_LSB)
                + frame_byte(frame, TEMP_INT_LSB) + frame_byte(frame, TEMP_DEC_LSB);
        match_c = (sum == frame_byte(frame, CSUM_LSB));
    end

endmodule

// File: rtl/dht11_poll_ctrl.sv
// dht11_poll_ctrl: sequencer driving a DHT11 single-wire reader.
// Issues a stretched start pulse, waits for the reader's done edge with a timeout,
// re-checks the frame checksum locally, latches good readings and enforces the
// minimum re-read gap. Supports single-shot (req) and free-running (auto_en) polling.
// Optional build macro DHT11_RETRY_EN adds MAX_RETRY automatic retries per failure.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             single-shot request, latched as pending
//   auto_en         free-running poll enable
//   sens_start      start request to the reader
//   sens_data       40-bit frame from the reader
//   sens_done       reader done level
//   sens_error      reader's own checksum flag (cross-check counter only)
//   hum_int, hum_dec, temp_int, temp_dec   last good reading
//   valid           one-cycle pulse when a good reading is latched
//   status          last result: 00 ok, 01 checksum, 10 timeout, 11 never run
//   busy            high outside IDLE
//   err_cnt         saturating failed-transaction count
module dht11_poll_ctrl
    import dht11_pkg::*;
#(
    parameter int unsigned START_HOLD_CYC = 128,
    parameter int unsigned TIMEOUT_CYC    = 2_500_000,
    parameter int unsigned GAP_CYC        = 50_000_000,
    parameter int unsigned CNT_W          = 26
`ifdef DHT11_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY      = 2
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               auto_en,
    output logic               sens_start,
    input  logic [FRAME_W-1:0] sens_data,
    input  logic               sens_done,
    input  logic               sens_error,
    output logic [BYTE_W-1:0]  hum_int,
    output logic [BYTE_W-1:0]  hum_dec,
    output logic [BYTE_W-1:0]  temp_int,
    output logic [BYTE_W-1:0]  temp_dec,
    output logic               valid,
    output logic [1:0]         status,
    output logic               busy,
    output logic [BYTE_W-1:0]  err_cnt
);

    logic [STATE_W-1:0] state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               pending, pending_nx;
    logic               done_q;
    dht11_frame_t       frame_q, frame_nx;
    logic [BYTE_W-1:0]  hum_int_nx, hum_dec_nx, temp_int_nx, temp_dec_nx;
    logic [1:0]         status_nx;
    logic [BYTE_W-1:0]  err_cnt_nx;
    logic               valid_nx, sens_start_nx, busy_nx;
    logic [BYTE_W-1:0]  mismatch_cnt, mismatch_cnt_nx;
    logic               done_rise_c;
    logic               csum_ok_c;
    logic               fail_c;
    logic [1:0]         fail_code_c;
`ifdef DHT11_RETRY_EN
    logic [BYTE_W-1:0]  retry, retry_nx;
    logic               retry_due, retry_due_nx;
`endif

    assign done_rise_c = sens_done & ~done_q;

    // Local checksum check on the captured frame
    dht11_csum u_csum (
        .frame   (frame_q),
        .match_c (csum_ok_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt + CNT_W'(1);
        pending_nx      = pending | req;
        frame_nx        = frame_q;
        hum_int_nx      = hum_int;
        hum_dec_nx      = hum_dec;
        temp_int_nx     = temp_int;
        temp_dec_nx     = temp_dec;
        status_nx       = status;
        err_cnt_nx      = err_cnt;
        valid_nx        = 1'b0;
        mismatch_cnt_nx = mismatch_cnt;
        fail_c          = 1'b0;
        fail_code_c     = ST_NONE;
`ifdef DHT11_RETRY_EN
        retry_nx        = retry;
        retry_due_nx    = retry_due;
`endif

        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (pending || auto_en) begin
                    state_nx   = S_START;
                    pending_nx = 1'b0;
                end
            end

            S_START: begin
                if (cnt == CNT_W'(START_HOLD_CYC - 1)) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end
            end

            S_WAIT: begin
                if (done_rise_c) begin
                    frame_nx = dht11_frame_t'(sens_data);
                    state_nx = S_CHECK;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    fail_c      = 1'b1;
                    fail_code_c = ST_TIMEOUT;
                    state_nx    = S_GAP;
                    cnt_nx      = '0;
                end
            end

            S_CHECK: begin
                state_nx = S_GAP;
                cnt_nx   = '0;
                if (csum_ok_c) begin
                    hum_int_nx  = frame_q.hum_int;
                    hum_dec_nx  = frame_q.hum_dec;
                    temp_int_nx = frame_q.temp_int;
                    temp_dec_nx = frame_q.temp_dec;
                    status_nx   = ST_OK;
                    valid_nx    = 1'b1;
`ifdef DHT11_RETRY_EN
                    retry_nx    = '0;
`endif
                end else begin
                    fail_c      = 1'b1;
                    fail_code_c = ST_CSUM;
                end
                // Reader's flag disagreeing with the local verdict is only counted
                if ((sens_error == csum_ok_c) && (mismatch_cnt != 8'hFF)) begin
                    mismatch_cnt_nx = mismatch_cnt + 8'd1;
                end
            end

            S_GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    cnt_nx = '0;
`ifdef DHT11_RETRY_EN
                    if (retry_due) begin
                        state_nx     = S_START;
                        pending_nx   = 1'b0;
                        retry_due_nx = 1'b0;
                        retry_nx     = retry + 8'd1;
                    end else begin
                        state_nx = S_IDLE;
                    end
`else
                    state_nx = S_IDLE;
`endif
                end
            end

            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Failure reporting; with retries enabled only the final failure is reported
        if (fail_c) begin
`ifdef DHT11_RETRY_EN
            if (retry < 8'(MAX_RETRY)) begin
                retry_due_nx = 1'b1;
            end else begin
                status_nx = fail_code_c;
                if (err_cnt != 8'hFF) begin
                    err_cnt_nx = err_cnt + 8'd1;
                end
                retry_nx = '0;
            end
`else
            status_nx = fail_code_c;
            if (err_cnt != 8'hFF) begin
                err_cnt_nx = err_cnt + 8'd1;
            end
`endif
        end

        sens_start_nx = (state_nx == S_START);
        busy_nx       = (state_nx != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            pending      <= 1'b0;
            done_q       <= 1'b0;
            frame_q      <= '0;
            hum_int      <= '0;
            hum_dec      <= '0;
            temp_int     <= '0;
            temp_dec     <= '0;
            status       <= ST_NONE;
            err_cnt      <= '0;
            valid        <= 1'b0;
            sens_start   <= 1'b0;
            busy         <= 1'b0;
            mismatch_cnt <= '0;
`ifdef DHT11_RETRY_EN
            retry        <= '0;
            retry_due    <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pending      <= pending_nx;
            done_q       <= sens_done;
            frame_q      <= frame_nx;
            hum_int      <= hum_int_nx;
            hum_dec      <= hum_dec_nx;
            temp_int     <= temp_int_nx;
            temp_dec     <= temp_dec_nx;
            status       <= status_nx;
            err_cnt      <= err_cnt_nx;
            valid        <= valid_nx;
            sens_start   <= sens_start_nx;
            busy         <= busy_nx;
            mismatch_cnt <= mismatch_cnt_nx;
`ifdef DHT11_RETRY_EN
            retry        <= retry_nx;
            retry_due    <= retry_due_nx;
`endif
        end
    end

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// tb_dht11_poll_ctrl: self-checking bench for dht11_poll_ctrl with small timing parameters.
// A behavioural reader model answers start pulses; a reference model of the last
// reading, status and error count is updated from the checksum rule.
module tb_dht11_poll_ctrl;

    localparam int unsigned HOLD = 4;
    localparam int unsigned TMO  = 50;
    localparam int unsigned GAP  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        auto_en;
    logic        sens_start;
    logic [39:0] sens_data;
    logic        sens_done;
    logic        sens_error;
    logic [7:0]  hum_int, hum_dec, temp_int, temp_dec;
    logic        valid;
    logic [1:0]  status;
    logic        busy;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_hi, m_hd, m_ti, m_td, m_err;
    logic [1:0] m_st;

    always #5 clk = ~clk;

    dht11_poll_ctrl #(
        .START_HOLD_CYC (HOLD),
        .TIMEOUT_CYC    (TMO),
        .GAP_CYC        (GAP),
        .CNT_W          (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .auto_en    (auto_en),
        .sens_start (sens_start),
        .sens_data  (sens_data),
        .sens_done  (sens_done),
        .sens_error (sens_error),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
        .valid      (valid),
        .status     (status),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic bit csum_ok(input logic [39:0] f);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return (s % 256) == int'(f[7:0]);
    endfunction

    function automatic logic [39:0] rand_frame(input bit good);
        logic [39:0] f;
        int s, c;
        f[39:8] = $urandom;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        c = s % 256;
        if (!good) c = (c + 1 + int'($urandom_range(0, 254))) % 256;
        f[7:0] = 8'(c);
        return f;
    endfunction

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    // Serve one transaction as the reader; returns at the negedge where the outcome is visible
    task automatic run_txn(input logic [39:0] frame, input int dly, input bit respond);
        int n;
        bit ok;
        logic [1:0] old_st;
        n = 0;
        while (sens_start !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (sens_start !== 1'b1) begin
            failures++;
            $display("FAIL start_rise: sens_start=%b after %0d cycles, required 1", sens_start, n);
            return;
        end
        n = 0;
        while (sens_start === 1'b1 && n < int'(HOLD) + 8) begin
            tick();
            n++;
        end
        checks++;
        if (n != int'(HOLD) || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_hold: high %0d cycles busy=%b, required %0d cycles busy=1", n, busy, HOLD);
        end
        old_st = m_st;
        if (respond) begin
            repeat (dly) tick();
            ok         = csum_ok(frame);
            sens_data  = frame;
            sens_done  = 1'b1;
            sens_error = !ok;
            tick();
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL valid_early: valid=%b, required 0", valid);
            end
            tick();
            if (ok) begin
                m_hi = frame[39:32];
                m_hd = frame[31:24];
                m_ti = frame[23:16];
                m_td = frame[15:8];
                m_st = 2'b00;
            end else begin
                m_st = 2'b01;
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
            end
            checks++;
            if (valid !== ok) begin
                failures++;
                $display("FAIL valid_pulse: valid=%b, required %b (frame %h)", valid, ok, frame);
            end
        end else begin
            repeat (TMO - 1) tick();
            checks++;
            if (status !== old_st || busy !== 1'b1) begin
                failures++;
                $display("FAIL timeout_early: status=%b busy=%b, required %b/1", status, busy, old_st);
            end
            tick();
            m_st = 2'b10;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        checks++;
        if ({hum_int, hum_dec, temp_int, temp_dec, status, err_cnt} !==
            {m_hi, m_hd, m_ti, m_td, m_st, m_err}) begin
            failures++;
            $display("FAIL outcome: data=%h_%h_%h_%h status=%b err=%0d, required %h_%h_%h_%h status=%b err=%0d",
                     hum_int, hum_dec, temp_int, temp_dec, status, err_cnt,
                     m_hi, m_hd, m_ti, m_td, m_st, m_err);
        end
    endtask

    // Walk the gap after an outcome; optionally inject a req 5 cycles in
    task automatic check_gap(input bit restart, input bit inject);
        for (int i = 1; i < int'(GAP); i++) begin
            tick();
            if (i == 2) sens_done = 1'b0;
            req = inject && (i == 5);
            checks++;
            if (busy !== 1'b1 || valid !== 1'b0 || sens_start !== 1'b0) begin
                failures++;
                $display("FAIL gap_busy: gap cycle %0d busy=%b valid=%b sens_start=%b, required 1/0/0",
                         i, busy, valid, sens_start);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || sens_start !== 1'b0) begin
            failures++;
            $display("FAIL gap_end: busy=%b sens_start=%b, required 0/0", busy, sens_start);
        end
        tick();
        checks++;
        if (sens_start !== restart || busy !== restart) begin
            failures++;
            $display("FAIL restart: sens_start=%b busy=%b, required %b/%b", sens_start, busy, restart, restart);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; auto_en = 1'b0;
        sens_data = '0; sens_done = 1'b0; sens_error = 1'b0;
        m_hi = 8'h00; m_hd = 8'h00; m_ti = 8'h00; m_td = 8'h00; m_err = 8'h00; m_st = 2'b11;
        repeat (3) tick();
        checks++;
        if ({sens_start, valid, busy, hum_int, hum_dec, temp_int, temp_dec, status, err_cnt} !==
            {3'b000, 32'h0, 2'b11, 8'h00}) begin
            failures++;
            $display("FAIL reset_state: start=%b valid=%b busy=%b status=%b err=%0d, required 0/0/0/11/0",
                     sens_start, valid, busy, status, err_cnt);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (sens_start !== 1'b0 || busy !== 1'b0 || status !== 2'b11) begin
            failures++;
            $display("FAIL idle_after_reset: start=%b busy=%b status=%b, required 0/0/11",
                     sens_start, busy, status);
        end
    endtask

    task automatic test_good_frame();
        pulse_req();
        checks++;
        if (sens_start !== 1'b0) begin
            failures++;
            $display("FAIL req_latency: sens_start=%b one cycle after req, required 0", sens_start);
        end
        run_txn(40'h35_00_18_00_4D, 10, 1'b1);
        checks++;
        if (hum_int !== 8'h35 || temp_int !== 8'h18 || status !== 2'b00 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL good_frame: hum=%h temp=%h status=%b err=%0d, required 35/18/00/0",
                     hum_int, temp_int, status, err_cnt);
        end
        check_gap(1'b0, 1'b0);
    endtask

    task automatic test_bad_csum();
        pulse_req();
        run_txn(40'h35_00_18_00_4E, 10, 1'b1);
        checks++;
        if (hum_int !== 8'h35 || temp_int !== 8'h18 || status !== 2'b01 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL bad_csum: hum=%h temp=%h status=%b err=%0d, required 35/18/01/1",
                     hum_int, temp_int, status, err_cnt);
        end
        check_gap(1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        pulse_req();
        run_txn(40'h0, 0, 1'b0);
        check_gap(1'b0, 1'b0);
    endtask

    task automatic test_req_during_gap();
        pulse_req();
        run_txn(rand_frame(1'b1), int'($urandom_range(1, 40)), 1'b1);
        check_gap(1'b1, 1'b1);
        run_txn(rand_frame(1'b1), int'($urandom_range(1, 40)), 1'b1);
        check_gap(1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit chain;
        bit inj;
        chain = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (!chain) pulse_req();
            inj = ($urandom_range(0, 1) == 1);
            run_txn(rand_frame($urandom_range(0, 2) != 0), int'($urandom_range(0, 40)),
                    $urandom_range(0, 4) != 0);
            check_gap(inj, inj);
            chain = inj;
        end
        if (chain) begin
            run_txn(rand_frame(1'b1), 5, 1'b1);
            check_gap(1'b0, 1'b0);
        end
    endtask

    task automatic test_wrap_auto();
        auto_en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            run_txn(40'hFF_FF_FF_FF_FC, int'($urandom_range(1, 30)), 1'b1);
            checks++;
            if (status !== 2'b00 || hum_int !== 8'hFF || temp_dec !== 8'hFF) begin
                failures++;
                $display("FAIL wrap_frame: status=%b hum=%h temp_dec=%h, required 00/ff/ff",
                         status, hum_int, temp_dec);
            end
            if (t == 2) auto_en = 1'b0;
            check_gap(t != 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        pulse_req();
        n = 0;
        while (sens_start !== 1'b1 && n < 50) begin tick(); n++; end
        while (sens_start === 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (sens_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reach_wait: sens_start=%b busy=%b, required 0/1", sens_start, busy);
        end
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        m_hi = 8'h00; m_hd = 8'h00; m_ti = 8'h00; m_td = 8'h00; m_err = 8'h00; m_st = 2'b11;
        checks++;
        if ({sens_start, busy, valid, status, err_cnt, hum_int} !== {3'b000, 2'b11, 16'h0}) begin
            failures++;
            $display("FAIL async_reset: start=%b busy=%b valid=%b status=%b err=%0d hum=%h, required 0/0/0/11/0/00",
                     sens_start, busy, valid, status, err_cnt, hum_int);
        end
        tick();
        rst = 1'b0;
        sens_data = 40'h35_00_18_00_4D; sens_done = 1'b1; sens_error = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0 || status !== m_st || hum_int !== m_hi) begin
                failures++;
                $display("FAIL done_ignored: cycle %0d busy=%b valid=%b status=%b hum=%h, required 0/0/%b/%h",
                         i, busy, valid, status, hum_int, m_st, m_hi);
            end
        end
        sens_done = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_timeout();
        test_req_during_gap();
        test_random();
        test_wrap_auto();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
